// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sequence controller.
// Holds the state encoding, table field codes and timing constants.
package pwm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_STOP
  } state_e;

  typedef enum logic [1:0] {
    SEL_PULSE_W = 2'd0,
    SEL_GAP_W   = 2'd1,
    SEL_TIMES   = 2'd2,
    SEL_LEVEL   = 2'd3
  } cfg_sel_e;

  localparam int unsigned GAP_LEN    = 2;
  localparam int unsigned STOP_QUIET = 2;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pwm_cfg_table.sv
// Sequence table: one register per field per entry.
// Single write port, asynchronous read of a whole entry.
module pwm_cfg_table
  import pwm_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    sel_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  pulse_w_o,
  output logic [W-1:0]  gap_w_o,
  output logic [W-1:0]  times_o,
  output logic          level_o
);

  logic [W-1:0] pulse_w_q [DEPTH];
  logic [W-1:0] gap_w_q   [DEPTH];
  logic [W-1:0] times_q   [DEPTH];
  logic         level_q   [DEPTH];

  logic wr_ok;
  assign wr_ok = we_i && (32'(addr_i) < DEPTH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pulse_w_q[i] <= '0;
        gap_w_q[i]   <= '0;
        times_q[i]   <= '0;
        level_q[i]   <= 1'b0;
      end
    end else if (wr_ok) begin
      unique case (1'b1)
        sel_i == SEL_PULSE_W: pulse_w_q[addr_i] <= wdata_i;
        sel_i == SEL_GAP_W:   gap_w_q[addr_i]   <= wdata_i;
        sel_i == SEL_TIMES:   times_q[addr_i]   <= wdata_i;
        sel_i == SEL_LEVEL:   level_q[addr_i]   <= wdata_i[0];
      endcase
    end
  end

  assign pulse_w_o = pulse_w_q[raddr_i];
  assign gap_w_o   = gap_w_q[raddr_i];
  assign times_o   = times_q[raddr_i];
  assign level_o   = level_q[raddr_i];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Steps a pulse generator through a table of pulse configs,
// with fixed gaps between entries, optional looping and abort.
module pwm_seq_ctrl
  import pwm_pkg::*;
#(
  parameter  int _RAM_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int AW         = idx_w(DEPTH)
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [1:0]            cfg_sel,
  input  logic [_RAM_WIDTH-1:0] cfg_wdata,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [AW-1:0]         last_idx,
  output logic                  pwm_en,
  output logic                  pwm_default_level,
  output logic [_RAM_WIDTH-1:0] pwm_pulse_width,
  output logic [_RAM_WIDTH-1:0] pwm_unaccess_width,
  output logic [_RAM_WIDTH-1:0] pwm_pulse_times,
  input  logic                  pwm_pulse_valid,
  input  logic                  pwm_pulse_busy,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_abort,
  output logic [AW-1:0]         cur_idx
);

  localparam int W = _RAM_WIDTH;
  localparam logic [1:0] GAP_LAST  = 2'(GAP_LEN - 1);
  localparam logic [1:0] QUIET_LAST = 2'(STOP_QUIET - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;

  logic [W-1:0]  width_q, gap_q, times_q;
  logic          level_q;

  logic [W-1:0]  rd_width, rd_gap, rd_times;
  logic          rd_level;
  logic [AW-1:0] last_eff;

  pwm_cfg_table #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk_i     (io_clk),
    .rst_i     (io_rst),
    .we_i      (cfg_we),
    .addr_i    (cfg_addr),
    .sel_i     (cfg_sel),
    .wdata_i   (cfg_wdata),
    .raddr_i   (idx_q),
    .pulse_w_o (rd_width),
    .gap_w_o   (rd_gap),
    .times_o   (rd_times),
    .level_o   (rd_level)
  );

  // An out-of-range final index behaves as the last real entry.
  assign last_eff = (32'(last_idx) >= DEPTH) ? AW'(DEPTH - 1) : last_idx;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else if (rd_width == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else if (pwm_pulse_valid && times_q != '0) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else if (cnt_q == GAP_LAST) begin
          if (idx_q != last_eff) begin
            idx_d   = idx_q + AW'(1);
            state_d = S_LOAD;
          end else if (loop_en) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_STOP: begin
        // Wait for the generator to be quiet on consecutive cycles.
        if (pwm_pulse_busy) begin
          cnt_d = '0;
        end else if (cnt_q == QUIET_LAST) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      width_q <= '0;
      gap_q   <= '0;
      times_q <= '0;
      level_q <= 1'b0;
    end else if (state_q == S_LOAD) begin
      width_q <= rd_width;
      gap_q   <= rd_gap;
      times_q <= rd_times;
      level_q <= rd_level;
    end
  end

  assign pwm_en             = (state_q == S_RUN);
  assign pwm_default_level  = level_q;
  assign pwm_pulse_width    = width_q;
  assign pwm_unaccess_width = gap_q;
  assign pwm_pulse_times    = times_q;
  assign seq_busy           = (state_q != S_IDLE);
  assign seq_done           = done_q;
  assign seq_abort          = abort_q;
  assign cur_idx            = idx_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: directed and random sequences
// checked against an entry-level model of the sequencing rules.
module tb_pwm_seq_ctrl;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          io_clk = 1'b0;
  logic          io_rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [1:0]    cfg_sel;
  logic [W-1:0]  cfg_wdata;
  logic          start, stop, loop_en;
  logic [AW-1:0] last_idx;
  logic          pwm_en, pwm_default_level;
  logic [W-1:0]  pwm_pulse_width, pwm_unaccess_width, pwm_pulse_times;
  logic          pwm_pulse_valid, pwm_pulse_busy;
  logic          seq_busy, seq_done, seq_abort;
  logic [AW-1:0] cur_idx;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] m_w   [D];
  logic [W-1:0] m_gap [D];
  logic [W-1:0] m_tim [D];
  logic         m_lvl [D];

  pwm_seq_ctrl #(._RAM_WIDTH(W), .DEPTH(D)) dut (
    .io_clk             (io_clk),
    .io_rst             (io_rst),
    .cfg_we             (cfg_we),
    .cfg_addr           (cfg_addr),
    .cfg_sel            (cfg_sel),
    .cfg_wdata          (cfg_wdata),
    .start              (start),
    .stop               (stop),
    .loop_en            (loop_en),
    .last_idx           (last_idx),
    .pwm_en             (pwm_en),
    .pwm_default_level  (pwm_default_level),
    .pwm_pulse_width    (pwm_pulse_width),
    .pwm_unaccess_width (pwm_unaccess_width),
    .pwm_pulse_times    (pwm_pulse_times),
    .pwm_pulse_valid    (pwm_pulse_valid),
    .pwm_pulse_busy     (pwm_pulse_busy),
    .seq_busy           (seq_busy),
    .seq_done           (seq_done),
    .seq_abort          (seq_abort),
    .cur_idx            (cur_idx)
  );

  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic wr(input int a, input int s, input logic [W-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_sel   = 2'(s);
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic set_entry(input int a, input logic [W-1:0] w,
                           input logic [W-1:0] g, input logic [W-1:0] t,
                           input logic l);
    wr(a, 0, w);
    wr(a, 1, g);
    wr(a, 2, t);
    wr(a, 3, {{(W-1){1'b0}}, l});
    m_w[a]   = w;
    m_gap[a] = g;
    m_tim[a] = t;
    m_lvl[a] = l;
  endtask

  task automatic chk_cfg(input string tag, input int i);
    chk({tag, "_w"},   pwm_pulse_width,    m_w[i]);
    chk({tag, "_gap"}, pwm_unaccess_width, m_gap[i]);
    chk({tag, "_tim"}, pwm_pulse_times,    m_tim[i]);
    chk({tag, "_lvl"}, pwm_default_level,  m_lvl[i]);
  endtask

  // Walk one sequence; entry order follows from the table contents,
  // the final index and loop_en. Requires nonzero pulse counts.
  task automatic run_seq(input int last, input int loop_clear_win);
    int  idx, exp_last, win, hold;
    bit  fin;
    exp_last = (last >= D) ? D - 1 : last;
    last_idx = AW'(last);
    chk("pre_idle", seq_busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    win = 0;
    fin = 1'b0;
    for (int k = 0; k < 24 && !fin; k++) begin
      chk("load_en", pwm_en, 0);
      chk("load_idx", cur_idx, idx);
      chk("load_busy", seq_busy, 1);
      step();
      if (m_w[idx] == '0) begin
        chk("end0_done", seq_done, 1);
        chk("end0_busy", seq_busy, 0);
        chk("end0_en", pwm_en, 0);
        chk_cfg("end0_cfg", idx);
        fin = 1'b1;
      end else begin
        chk("run_en", pwm_en, 1);
        chk("run_idx", cur_idx, idx);
        chk_cfg("run_cfg", idx);
        hold = $urandom_range(0, 4);
        for (int h = 0; h < hold; h++) begin
          start = (h == 0);
          step();
          start = 1'b0;
          chk("hold_en", pwm_en, 1);
          chk("hold_w", pwm_pulse_width, m_w[idx]);
        end
        win++;
        if (win == loop_clear_win) loop_en = 1'b0;
        pwm_pulse_valid = 1'b1;
        step();
        pwm_pulse_valid = 1'b0;
        chk("gap1_en", pwm_en, 0);
        chk("gap1_busy", seq_busy, 1);
        step();
        chk("gap2_en", pwm_en, 0);
        chk("gap2_busy", seq_busy, 1);
        step();
        if (idx != exp_last) begin
          idx++;
        end else if (loop_en) begin
          idx = 0;
        end else begin
          chk("end_done", seq_done, 1);
          chk("end_busy", seq_busy, 0);
          fin = 1'b1;
        end
      end
    end
    chk("seq_finished", fin, 1);
    chk("seq_no_abort", seq_abort, 0);
    step();
    chk("done_one_cycle", seq_done, 0);
  endtask

  task automatic go_run();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  initial begin
    io_rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = '0;
    pwm_pulse_valid = 1'b0; pwm_pulse_busy = 1'b0;
    for (int i = 0; i < D; i++) begin
      m_w[i] = '0; m_gap[i] = '0; m_tim[i] = '0; m_lvl[i] = 1'b0;
    end
    step();
    step();
    chk("rst_en", pwm_en, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_abort", seq_abort, 0);
    chk("rst_idx", cur_idx, 0);
    chk_cfg("rst_cfg", 0);
    io_rst = 1'b0;
    step();

    set_entry(0, 3, 2, 2, 1'b0);
    run_seq(0, 0);

    set_entry(0, 4, 11, 1, 1'b1);
    set_entry(1, 5, 12, 2, 1'b0);
    set_entry(2, 6, 13, 3, 1'b1);
    run_seq(2, 0);

    set_entry(0, 7, 3, 1, 1'b1);
    set_entry(1, 0, 9, 4, 1'b1);
    run_seq(3, 0);

    set_entry(0, 8, 1, 1, 1'b0);
    set_entry(1, 9, 2, 2, 1'b1);
    loop_en = 1'b1;
    run_seq(1, 3);
    loop_en = 1'b0;

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < D; i++) begin
        set_entry(i,
                  ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 255)),
                  W'($urandom),
                  W'($urandom_range(1, 7)),
                  1'($urandom_range(0, 1)));
      end
      run_seq($urandom_range(0, D - 1), 0);
    end

    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", seq_busy, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop_busy", seq_busy, 0);
    chk("idle_stop_abort", seq_abort, 0);

    // Continuous entry, aborted by stop while the generator stays busy.
    set_entry(0, 9, 3, 0, 1'b1);
    last_idx = '0;
    pwm_pulse_busy = 1'b1;
    go_run();
    for (int c = 0; c < 50; c++) begin
      pwm_pulse_valid = (c == 10);
      chk("cont_en", pwm_en, 1);
      step();
    end
    pwm_pulse_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_en", pwm_en, 0);
    chk("stop_busy", seq_busy, 1);
    pwm_pulse_busy = 1'b0; step();
    chk("stop_q1", seq_busy, 1);
    pwm_pulse_busy = 1'b1; step();
    chk("stop_b", seq_busy, 1);
    pwm_pulse_busy = 1'b0; step();
    chk("stop_q1b", seq_busy, 1);
    chk("stop_no_abort_yet", seq_abort, 0);
    step();
    chk("abort_busy", seq_busy, 0);
    chk("abort_pulse", seq_abort, 1);
    chk("abort_no_done", seq_done, 0);
    step();
    chk("abort_one_cycle", seq_abort, 0);

    // Stop wins over a simultaneous pulse_valid.
    set_entry(0, 5, 1, 3, 1'b0);
    go_run();
    chk("prio_run", pwm_en, 1);
    stop = 1'b1; pwm_pulse_valid = 1'b1;
    step();
    stop = 1'b0; pwm_pulse_valid = 1'b0;
    chk("prio_en", pwm_en, 0);
    step();
    chk("prio_busy", seq_busy, 1);
    step();
    chk("prio_abort", seq_abort, 1);
    chk("prio_no_done", seq_done, 0);
    step();

    // Reset in the middle of RUN.
    set_entry(0, 8, 2, 1, 1'b1);
    go_run();
    chk("prerst_en", pwm_en, 1);
    #2 io_rst = 1'b1;
    #1;
    chk("midrst_en", pwm_en, 0);
    chk("midrst_busy", seq_busy, 0);
    chk("midrst_abort", seq_abort, 0);
    chk("midrst_w", pwm_pulse_width, 0);
    chk("midrst_lvl", pwm_default_level, 0);
    step();
    io_rst = 1'b0;
    for (int i = 0; i < D; i++) begin
      m_w[i] = '0; m_gap[i] = '0; m_tim[i] = '0; m_lvl[i] = 1'b0;
    end
    step();
    chk("postrst_abort", seq_abort, 0);
    run_seq(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
